// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-ported memory. Port 0 is the CPU,
// port 1 is the DMA/loader. One transaction is in flight at a time and each
// transaction takes exactly three cycles: IDLE (sample and latch the winner),
// ACCESS (drive the memory), DONE (pulse the winner's ack).
//
// Build option:
//   MEM_ARBITER_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate
//                                            between the ports (the port not
//                                            granted most recently wins).
//                               undefined -> fixed priority, port 0 wins.
//   A single requester is served identically in both builds.
//
// Parameters:
//   AW  memory address width (byte address, passed through unmodified)
//   DW  data width
//
// Ports:
//   clk               clock, all state changes on posedge
//   rst               synchronous active-high reset
//   req0/req1         access request per port
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       byte address per port
//   wdata0/wdata1     write data per port
//   ack0/ack1         one-cycle completion pulse per port
//   rdata0/rdata1     read data per port, held until that port's next ack
//   addr              shared memory address (zero outside ACCESS)
//   wr_data           shared memory write data (zero outside ACCESS)
//   en                memory write enable, commit at posedge when high
//   rd_data           memory read data, combinational from addr
//   state_dbg         current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a requester raises reqN together with weN/addrN/wdataN and keeps
// all of them stable until it sees ackN high for one cycle. Once the request
// has been latched in IDLE, dropping reqN does not cancel it. A request that
// is high during the DONE cycle is not sampled; it is considered again in the
// IDLE cycle that follows, so the best throughput is one access per 3 cycles.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wr_data,
  output logic          en,
  input  logic [DW-1:0] rd_data,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Latched transaction: winner index (0 = port 0, 1 = port 1) and operands.
  logic            win_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;

  logic            any_req;
  logic            grant;   // port that wins if a transaction starts now

  assign any_req   = req0 | req1;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_q remembers the most recently granted port. Resetting it to 1 makes
  // port 0 the preferred port for the first contended grant.
  logic last_q;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_q;
    end else begin
      grant = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_q <= grant;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  always_comb begin
    grant = 1'b0;
    if (!req0) begin
      grant = req1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. ACCESS and DONE always last exactly one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction latch and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        win_q   <= grant;
        we_q    <= grant ? we1    : we0;
        addr_q  <= grant ? addr1  : addr0;
        wdata_q <= grant ? wdata1 : wdata0;
      end
      // rd_data is valid during ACCESS of a read because en is low then.
      // Only the winner's read register moves; the other port keeps its data.
      if (state == ACCESS && !we_q) begin
        if (win_q) begin
          rdata1 <= rd_data;
        end else begin
          rdata0 <= rd_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    en      = 1'b0;
    addr    = '0;
    wr_data = '0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    if (state == ACCESS) begin
      addr    = addr_q;
      wr_data = wdata_q;
      // Gating with rst directly keeps a reset asserted during ACCESS from
      // committing a write, even though the state register is still ACCESS.
      en      = we_q & ~rst;
    end
    // ack decodes the registered state, so a reset during DONE still shows
    // the ack in that cycle and clears it from the next one.
    if (state == DONE) begin
      ack0 = ~win_q;
      ack1 = win_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter: a behavioural single-port memory, directed scenario
// tasks, and a randomized run checked against a transaction-timeline model of
// the arbiter (grant decision, access cycle, ack cycle, busy window).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, en;
  logic [15:0] rdata0, rdata1, addr, wr_data, rd_data;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .addr(addr), .wr_data(wr_data), .en(en), .rd_data(rd_data),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Memory: combinational read, write at posedge on en; a bench preload port
  // is used only while the arbiter is idle.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [0:65535];
  logic        pre_we = 0;
  logic [15:0] pre_addr = 0, pre_data = 0;

  assign rd_data = mem[addr];

  always @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int p, input bit w, input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) begin
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    end else begin
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b%b exp=00", ack0, ack1); end
    checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", rdata0, rdata1); end
    checks++; if (en !== 1'b0 || addr !== 16'h0 || wr_data !== 16'h0) begin failures++; $display("FAIL reset_mem_bus en=%b addr=%h wr_data=%h exp=0/0000/0000", en, addr, wr_data); end
    drop_req(0);
    rst = 1'b0;
  endtask

  task automatic test_read();
    bit en_seen;
    do_reset();
    poke(16'h03E8, 16'h0009);
    drive(0, 1'b0, 16'h03E8, 16'h0);          // cycle N
    en_seen = en;
    @(negedge clk);                            // N+1: ACCESS
    en_seen |= en;
    checks++; if (addr !== 16'h03E8) begin failures++; $display("FAIL read_addr got=%h exp=03e8", addr); end
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL read_early_ack got=%b exp=0", ack0); end
    @(negedge clk);                            // N+2: DONE
    en_seen |= en;
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin failures++; $display("FAIL read_ack got=%b%b exp=10", ack0, ack1); end
    checks++; if (rdata0 !== 16'h0009) begin failures++; $display("FAIL read_rdata0 got=%h exp=0009", rdata0); end
    drop_req(0);
    @(negedge clk);
    en_seen |= en;
    checks++; if (ack0 !== 1'b0 || rdata0 !== 16'h0009) begin failures++; $display("FAIL read_hold ack0=%b rdata0=%h exp=0/0009", ack0, rdata0); end
    checks++; if (en_seen !== 1'b0) begin failures++; $display("FAIL read_en_never got=%b exp=0", en_seen); end
  endtask

  task automatic test_write();
    int en_cnt;
    do_reset();
    drive(1, 1'b1, 16'h03EA, 16'h1234);
    en_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (en) begin
        en_cnt++;
        checks++; if (addr !== 16'h03EA || wr_data !== 16'h1234) begin failures++; $display("FAIL write_bus addr=%h wr_data=%h exp=03ea/1234", addr, wr_data); end
      end
      if (k == 2) begin
        checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin failures++; $display("FAIL write_ack got=%b%b exp=01", ack0, ack1); end
        drop_req(1);
      end
    end
    checks++; if (en_cnt != 1) begin failures++; $display("FAIL write_en_cycles got=%0d exp=1", en_cnt); end
    drive(0, 1'b0, 16'h03EA, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || rdata0 !== 16'h1234) begin failures++; $display("FAIL write_readback ack0=%b rdata0=%h exp=1/1234", ack0, rdata0); end
    drop_req(0);
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit e0, e1;
    do_reset();
    poke(16'h0010, 16'hAAAA);
    poke(16'h0020, 16'h5555);
    drive(0, 1'b0, 16'h0010, 16'h0);
    drive(1, 1'b0, 16'h0020, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e0 = (k % 3 == 2) && (!RR || ((k / 3) % 2 == 0));
      e1 = (k % 3 == 2) && RR && ((k / 3) % 2 == 1);
      checks++; if (ack0 !== e0 || ack1 !== e1) begin failures++; $display("FAIL contend_ack k=%0d got=%b%b exp=%b%b", k, ack0, ack1, e0, e1); end
      if (e0) begin
        checks++; if (rdata0 !== 16'hAAAA) begin failures++; $display("FAIL contend_rdata0 got=%h exp=aaaa", rdata0); end
      end
      if (e1) begin
        checks++; if (rdata1 !== 16'h5555) begin failures++; $display("FAIL contend_rdata1 got=%h exp=5555", rdata1); end
      end
    end
    drop_req(0);
    drop_req(1);
  endtask

  task automatic test_reset_access();
    do_reset();
    poke(16'h0100, 16'h1111);
    drive(0, 1'b1, 16'h0100, 16'hBEEF);
    @(negedge clk);                            // ACCESS cycle
    rst = 1'b1;
    #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL rstacc_en got=%b exp=0", en); end
    drop_req(0);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL rstacc_ack1 got=%b%b exp=00", ack0, ack1); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL rstacc_ack2 got=%b%b exp=00", ack0, ack1); end
    checks++; if (mem[16'h0100] !== 16'h1111) begin failures++; $display("FAIL rstacc_mem got=%h exp=1111", mem[16'h0100]); end
  endtask

  task automatic test_reset_done();
    do_reset();
    poke(16'h0040, 16'h0005);
    drive(1, 1'b0, 16'h0040, 16'h0);
    @(negedge clk);                            // ACCESS
    @(negedge clk);                            // DONE
    rst = 1'b1;
    #1;
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL rstdone_ack_same got=%b exp=1", ack1); end
    drop_req(1);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ack1 !== 1'b0 || rdata1 !== 16'h0) begin failures++; $display("FAIL rstdone_after ack1=%b rdata1=%h exp=0/0000", ack1, rdata1); end
  endtask

  task automatic test_isolation();
    do_reset();
    poke(16'h0040, 16'h0005);
    poke(16'h0042, 16'h0007);
    drive(1, 1'b0, 16'h0040, 16'h0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack1 !== 1'b1 || rdata1 !== 16'h0005) begin failures++; $display("FAIL iso_p1 ack1=%b rdata1=%h exp=1/0005", ack1, rdata1); end
    drop_req(1);
    @(negedge clk);
    drive(0, 1'b0, 16'h0042, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (rdata1 !== 16'h0005) begin failures++; $display("FAIL iso_rdata1 k=%0d got=%h exp=0005", k, rdata1); end
      if (k == 2) begin
        checks++; if (ack0 !== 1'b1 || rdata0 !== 16'h0007) begin failures++; $display("FAIL iso_p0 ack0=%b rdata0=%h exp=1/0007", ack0, rdata0); end
        drop_req(0);
      end
    end
  endtask

  // A request dropped right after it was latched still completes.
  task automatic test_drop();
    do_reset();
    drive(0, 1'b0, 16'h0042, 16'h0);
    @(negedge clk);
    drop_req(0);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL drop_early got=%b exp=0", ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || rdata0 !== 16'h0007) begin failures++; $display("FAIL drop_ack ack0=%b rdata0=%h exp=1/0007", ack0, rdata0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || en !== 1'b0) begin failures++; $display("FAIL drop_idle ack0=%b en=%b exp=0/0", ack0, en); end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against a transaction-timeline reference model
  // ---------------------------------------------------------------------------
  logic [15:0] mm [0:65535];   // model memory
  logic [15:0] exp_q[$];       // scoreboard: expected read data, in ack order

  task automatic test_random();
    bit          pend [2];
    bit          pw   [2];
    logic [15:0] pa   [2];
    logic [15:0] pd   [2];
    logic [15:0] mrd  [2];
    int          acc_cyc, ack_cyc, free_cyc;
    bit          mw, mwe, last, winner;
    logic [15:0] ma, md, got;
    bit          e_ack0, e_ack1, e_en;
    logic [15:0] e_addr;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      mm[16'h0200 + 16'(2 * i)] = v;
      poke(16'h0200 + 16'(2 * i), v);
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; mrd[p] = 0;
    end
    acc_cyc = -1; ack_cyc = -1; free_cyc = 0;
    mw = 0; mwe = 0; ma = 0; md = 0; last = 1'b1;
    exp_q.delete();

    for (int c = 0; c < 600; c++) begin
      e_ack0 = (c == ack_cyc) && !mw;
      e_ack1 = (c == ack_cyc) && mw;
      e_en   = (c == acc_cyc) && mwe;
      e_addr = (c == acc_cyc) ? ma : 16'h0;
      checks++; if (ack0 !== e_ack0 || ack1 !== e_ack1) begin failures++; $display("FAIL rand_ack c=%0d got=%b%b exp=%b%b", c, ack0, ack1, e_ack0, e_ack1); end
      checks++; if (en !== e_en || addr !== e_addr) begin failures++; $display("FAIL rand_bus c=%0d en=%b addr=%h exp=%b/%h", c, en, addr, e_en, e_addr); end
      checks++; if (rdata0 !== mrd[0] || rdata1 !== mrd[1]) begin failures++; $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h/%h", c, rdata0, rdata1, mrd[0], mrd[1]); end
      if ((e_ack0 || e_ack1) && !mwe && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        checks++; if ((mw ? rdata1 : rdata0) !== got) begin failures++; $display("FAIL rand_sb c=%0d got=%h exp=%h", c, mw ? rdata1 : rdata0, got); end
      end
      if (c == acc_cyc) begin
        if (mwe) mm[ma] = md;
        else begin
          mrd[mw] = mm[ma];
          exp_q.push_back(mm[ma]);
        end
      end
      // Requesters: release on ack, then maybe issue a new request.
      if (e_ack0) pend[0] = 0;
      if (e_ack1) pend[1] = 0;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          pw[p]   = 1'($urandom_range(0, 1));
          pa[p]   = 16'h0200 + 16'(2 * $urandom_range(0, 15));
          pd[p]   = 16'($urandom);
        end
        if (pend[p]) drive(p, pw[p], pa[p], pd[p]);
        else drop_req(p);
      end
      // Model: a transaction can start only when the arbiter is free.
      if (c >= free_cyc && (pend[0] || pend[1])) begin
        winner   = (pend[0] && pend[1]) ? (RR ? !last : 1'b0) : pend[1];
        last     = winner;
        mw       = winner;
        mwe      = pw[winner];
        ma       = pa[winner];
        md       = pd[winner];
        acc_cyc  = c + 1;
        ack_cyc  = c + 2;
        free_cyc = c + 3;
      end
      @(negedge clk);
    end
    drop_req(0);
    drop_req(1);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_reset_access();
    test_reset_done();
    test_isolation();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
